// File: rtl/router_pkg.sv
// Shared definitions for the frame router arbiter: FSM state encoding and
// default sizing. DRAIN is used only when ARB_TIMEOUT_EN is defined.
package router_pkg;

    localparam int DEF_N           = 16;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_frame_arbiter_if.sv
// Request/forward bus of the round-robin frame arbiter.
// The slave modport is the arbiter side, the master modport the requester side.
// The timeout signal exists only when ARB_TIMEOUT_EN is defined.
interface rr_frame_arbiter_if
    import router_pkg::*;
#(
    parameter int N = DEF_N
);
    localparam int W = $clog2(N);

    logic [N-1:0] din;
    logic [N-1:0] valid_n;
    logic [N-1:0] frame_n;
    logic [N-1:0] busy;
    logic         frameo_n;
    logic         valido_n;
    logic         dout;
    logic [W-1:0] grant_idx;
    logic         granted;
`ifdef ARB_TIMEOUT_EN
    logic         timeout;
`endif

    modport slave (
        input  din, valid_n, frame_n,
        output busy, frameo_n, valido_n, dout, grant_idx, granted
`ifdef ARB_TIMEOUT_EN
        , output timeout
`endif
    );

    modport master (
        output din, valid_n, frame_n,
        input  busy, frameo_n, valido_n, dout, grant_idx, granted
`ifdef ARB_TIMEOUT_EN
        , input timeout
`endif
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping from N-1 back to 0. N need not be a power of two.
module rr_pick
    import router_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins last
    always_comb begin
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr} + (W + 1)'(i);
            cand_s = (cand_s >= (W + 1)'(N)) ? (cand_s - (W + 1)'(N)) : cand_s;
            idx    = req[cand_s[W-1:0]] ? cand_s[W-1:0] : idx;
            any    = any | req[cand_s[W-1:0]];
        end
    end

endmodule

// File: rtl/rr_frame_arbiter.sv
// Round-robin frame arbiter: grants the serial output to one requesting port
// for a whole frame and forwards its bits with one cycle of latency.
// Optional feature macro: ARB_TIMEOUT_EN (grant length limit, DRAIN state,
// timeout pulse). All outputs come straight from registers.
module rr_frame_arbiter
    import router_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic               clk,
    input logic               reset_n,
    rr_frame_arbiter_if.slave bus
);

    localparam int W = $clog2(N);

`ifdef ARB_TIMEOUT_EN
    localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          timeout_r;
    logic          timeout_s;
`endif

    arb_state_e   state_r;
    arb_state_e   state_s;
    logic [W-1:0] ptr_r;
    logic [W-1:0] ptr_s;
    logic [W-1:0] grant_idx_r;
    logic [W-1:0] grant_idx_s;
    logic [W-1:0] pick_idx_s;
    logic         pick_any_s;
    logic [N-1:0] req_s;
    logic [N-1:0] busy_r;
    logic [N-1:0] busy_s;
    logic         frameo_n_r;
    logic         frameo_n_s;
    logic         valido_n_r;
    logic         valido_n_s;
    logic         dout_r;
    logic         dout_s;
    logic         granted_r;
    logic         granted_s;
    logic         own_frame_s;

    // Pointer position just after the releasing owner, wrapping at N-1
    function automatic logic [W-1:0] ptr_after(input logic [W-1:0] idx);
        if (idx == W'(N - 1)) begin
            return '0;
        end else begin
            return idx + W'(1);
        end
    endfunction

    // busy pattern while port idx owns the output: everyone else is blocked
    function automatic logic [N-1:0] owner_busy(input logic [W-1:0] idx);
        return ~({{(N - 1){1'b0}}, 1'b1} << idx);
    endfunction

    assign req_s       = ~bus.frame_n;
    assign own_frame_s = bus.frame_n[grant_idx_r];

    rr_pick #(.N(N)) u_pick (
        .req (req_s),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Next state and round-robin pointer; the pointer only moves on release
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (own_frame_s) begin
                    state_s = IDLE;
                    ptr_s   = ptr_after(grant_idx_r);
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_r == CNT_LAST) begin
                    state_s = DRAIN;
                end
`endif
                else begin
                    state_s = GRANT;
                end
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
                if (own_frame_s) begin
                    state_s = IDLE;
                    ptr_s   = ptr_after(grant_idx_r);
                end else begin
                    state_s = DRAIN;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                ptr_s   = '0;
            end
        endcase
    end

    // Values the outputs take after this edge; idle values unless a port is forwarded
    always_comb begin
        frameo_n_s  = 1'b1;
        valido_n_s  = 1'b1;
        dout_s      = 1'b0;
        busy_s      = '0;
        grant_idx_s = '0;
        granted_s   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_s       = '0;
        timeout_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    frameo_n_s  = bus.frame_n[pick_idx_s];
                    valido_n_s  = bus.valid_n[pick_idx_s];
                    dout_s      = bus.din[pick_idx_s];
                    busy_s      = owner_busy(pick_idx_s);
                    grant_idx_s = pick_idx_s;
                    granted_s   = 1'b1;
                end else begin
                    granted_s   = 1'b0;
                end
            end
            GRANT: begin
                frameo_n_s = bus.frame_n[grant_idx_r];
                valido_n_s = bus.valid_n[grant_idx_r];
                dout_s     = bus.din[grant_idx_r];
                if (own_frame_s) begin
                    // final bit goes out; ownership ends on this edge
                    granted_s = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_r == CNT_LAST) begin
                    // grant held too long: silence the output but keep others blocked
                    frameo_n_s  = 1'b1;
                    valido_n_s  = 1'b1;
                    dout_s      = 1'b0;
                    busy_s      = owner_busy(grant_idx_r);
                    grant_idx_s = grant_idx_r;
                    timeout_s   = 1'b1;
                end
`endif
                else begin
                    busy_s      = owner_busy(grant_idx_r);
                    grant_idx_s = grant_idx_r;
                    granted_s   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_s       = cnt_r + CW'(1);
`endif
                end
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
                if (own_frame_s) begin
                    granted_s = 1'b0;
                end else begin
                    busy_s      = owner_busy(grant_idx_r);
                    grant_idx_s = grant_idx_r;
                end
            end
`endif
            default: begin
                granted_s = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            grant_idx_r <= '0;
            busy_r      <= '0;
            frameo_n_r  <= 1'b1;
            valido_n_r  <= 1'b1;
            dout_r      <= 1'b0;
            granted_r   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_r       <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            grant_idx_r <= grant_idx_s;
            busy_r      <= busy_s;
            frameo_n_r  <= frameo_n_s;
            valido_n_r  <= valido_n_s;
            dout_r      <= dout_s;
            granted_r   <= granted_s;
`ifdef ARB_TIMEOUT_EN
            cnt_r       <= cnt_s;
            timeout_r   <= timeout_s;
`endif
        end
    end

    assign bus.busy      = busy_r;
    assign bus.frameo_n  = frameo_n_r;
    assign bus.valido_n  = valido_n_r;
    assign bus.dout      = dout_r;
    assign bus.grant_idx = grant_idx_r;
    assign bus.granted   = granted_r;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_r;
`endif

endmodule

// File: tb/tb_rr_frame_arbiter.sv
// Self-checking bench for rr_frame_arbiter: requesters that send whole frames,
// a behavioural reference of ownership and round-robin order, per-cycle
// comparison of every output, plus directed scenarios with literal results.
module tb_rr_frame_arbiter;
    import router_pkg::*;

    localparam int N = DEF_N;
    localparam int W = $clog2(N);
    localparam int T = 16;

    typedef logic [N-1:0] vec_t;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    rr_frame_arbiter_if #(.N(N)) bus ();

    rr_frame_arbiter #(.N(N), .TIMEOUT_CYC(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // requester side: a wanting port holds frame_n low until its last bit
    bit want [N];
    int rem  [N];

    // reference model: who owns the output, where the search starts next
    int   owner    = -1;
    int   ptr_m    = 0;
    int   held     = 0;
    bit   draining = 1'b0;
    bit   consumed [N];
    logic e_fo, e_vo, e_do, e_gr, e_to;
    vec_t e_busy;
    logic [W-1:0] e_gidx;
    int   grant_log [$];
    int   grant_cyc [$];
    int   to_log    [$];

    function automatic logic bit_at(input vec_t v, input int c);
        vec_t s;
        s = v >> c;
        return s[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic quiet();
        e_fo = 1'b1;
        e_vo = 1'b1;
        e_do = 1'b0;
    endtask

    task automatic go_idle();
        quiet();
        e_gr   = 1'b0;
        e_gidx = '0;
        e_busy = '0;
    endtask

    task automatic fwd(input int k);
        e_fo = bit_at(bus.frame_n, k);
        e_vo = bit_at(bus.valid_n, k);
        e_do = bit_at(bus.din, k);
    endtask

    task automatic drive_inputs();
        vec_t fn;
        fn = '1;
        for (int i = 0; i < N; i++) begin
            if (want[i] && rem[i] >= 2) fn = fn & ~(vec_t'(1'b1) << i);
        end
        bus.frame_n = fn;
        bus.valid_n = vec_t'($urandom);
        bus.din     = vec_t'($urandom);
    endtask

    // expected outputs after the coming edge, from the inputs now applied
    task automatic model_step();
        int k;
        int c;
        k    = -1;
        e_to = 1'b0;
        for (int i = 0; i < N; i++) consumed[i] = 1'b0;
        if (reset_n === 1'b0) begin
            owner    = -1;
            ptr_m    = 0;
            draining = 1'b0;
            go_idle();
        end else if (owner < 0) begin
            for (int j = 0; j < N; j++) begin
                c = (ptr_m + j) % N;
                if (k < 0 && bit_at(bus.frame_n, c) == 1'b0) k = c;
            end
            if (k >= 0) begin
                owner       = k;
                held        = 1;
                draining    = 1'b0;
                consumed[k] = 1'b1;
                grant_log.push_back(k);
                grant_cyc.push_back(cyc + 1);
                fwd(k);
                e_gr   = 1'b1;
                e_gidx = W'(k);
                e_busy = ~(vec_t'(1'b1) << k);
            end else begin
                go_idle();
            end
        end else begin
            consumed[owner] = 1'b1;
            if (bit_at(bus.frame_n, owner) == 1'b1) begin
                if (draining) quiet();
                else fwd(owner);
                ptr_m    = (owner + 1) % N;
                owner    = -1;
                draining = 1'b0;
                e_gr     = 1'b0;
                e_gidx   = '0;
                e_busy   = '0;
            end else if (draining) begin
                quiet();
                e_gr = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (held == T) begin
                draining = 1'b1;
                quiet();
                e_gr = 1'b0;
                e_to = 1'b1;
            end
`endif
            else begin
                held++;
                fwd(owner);
                e_gr = 1'b1;
            end
        end
    endtask

    // one clock: drive, predict, sample #1 after the edge, compare, advance requesters
    task automatic cycle();
        drive_inputs();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("frameo_n",  32'(bus.frameo_n),  32'(e_fo));
        check("valido_n",  32'(bus.valido_n),  32'(e_vo));
        check("dout",      32'(bus.dout),      32'(e_do));
        check("busy",      32'(bus.busy),      32'(e_busy));
        check("grant_idx", 32'(bus.grant_idx), 32'(e_gidx));
        check("granted",   32'(bus.granted),   32'(e_gr));
`ifdef ARB_TIMEOUT_EN
        check("timeout",   32'(bus.timeout),   32'(e_to));
        if (bus.timeout === 1'b1) to_log.push_back(cyc);
`endif
        for (int i = 0; i < N; i++) begin
            if (reset_n === 1'b0) begin
                want[i] = 1'b0;
            end else if (consumed[i]) begin
                if (rem[i] <= 1) want[i] = 1'b0;
                else rem[i] = rem[i] - 1;
            end
        end
    endtask

    function automatic int pending();
        int p;
        p = (owner >= 0) ? 1 : 0;
        for (int i = 0; i < N; i++) p = p + int'(want[i]);
        return p;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        int pend;
        n    = 0;
        pend = pending();
        while (pend != 0 && n < budget) begin
            cycle();
            n++;
            pend = pending();
        end
        check("drain_budget", 32'(pend), 32'd0);
    endtask

    task automatic start(input int port, input int len);
        want[port] = 1'b1;
        rem[port]  = len;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            want[i] = 1'b0;
            rem[i]  = 0;
        end
        reset_n = 1'b0;
        repeat (2) cycle();
        check("reset_busy",    32'(bus.busy),     32'd0);
        check("reset_frameo",  32'(bus.frameo_n), 32'd1);
        reset_n = 1'b1;

        // single 9-bit frame on port 5
        start(5, 9);
        cycle();
        check("p5_granted", 32'(bus.granted),   32'd1);
        check("p5_idx",     32'(bus.grant_idx), 32'd5);
        check("p5_busy",    32'(bus.busy),      32'h0000FFDF);
        check("p5_frameo",  32'(bus.frameo_n),  32'd0);
        run_until_idle(20);
        check("p5_len", 32'(grant_cyc.size()), 32'd1);

        // simultaneous requests straight after reset: order 3, 7, 12
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        grant_log.delete();
        grant_cyc.delete();
        start(3, 5);
        start(7, 5);
        start(12, 5);
        run_until_idle(60);
        check("order_n",  32'(grant_log.size()), 32'd3);
        check("order_0",  32'(grant_log[0]), 32'd3);
        check("order_1",  32'(grant_log[1]), 32'd7);
        check("order_2",  32'(grant_log[2]), 32'd12);
        check("gap_0",    32'(grant_cyc[1] - grant_cyc[0]), 32'd5);
        check("gap_1",    32'(grant_cyc[2] - grant_cyc[1]), 32'd5);

        // wrap-around from pointer 14: port 15 before port 2
        start(13, 3);
        run_until_idle(20);
        check("ptr_after_13", 32'(ptr_m), 32'd14);
        grant_log.delete();
        start(2, 4);
        start(15, 4);
        run_until_idle(30);
        check("wrap_0", 32'(grant_log[0]), 32'd15);
        check("wrap_1", 32'(grant_log[1]), 32'd2);
        check("ptr_after_2", 32'(ptr_m), 32'd3);

        // reset on the fourth cycle of a port-9 frame
        start(9, 20);
        repeat (3) cycle();
        reset_n = 1'b0;
        cycle();
        check("rst_granted", 32'(bus.granted),   32'd0);
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_frameo",  32'(bus.frameo_n),  32'd1);
        check("rst_idx",     32'(bus.grant_idx), 32'd0);
        reset_n = 1'b1;
        grant_log.delete();
        start(0, 3);
        start(15, 3);
        run_until_idle(20);
        check("post_rst_0", 32'(grant_log[0]), 32'd0);
        check("post_rst_1", 32'(grant_log[1]), 32'd15);

`ifdef ARB_TIMEOUT_EN
        // port 1 holds its frame past the limit; port 4 waits behind it
        grant_log.delete();
        grant_cyc.delete();
        to_log.delete();
        start(1, 41);
        cycle();
        start(4, 4);
        run_until_idle(80);
        check("to_count", 32'(to_log.size()), 32'd1);
        check("to_cycle", 32'(to_log[0] - grant_cyc[0]), 32'd16);
        check("to_next",  32'(grant_log[1]), 32'd4);
`endif

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 11) == 0) start(i, int'($urandom_range(2, 24)));
            end
            reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            cycle();
        end
        reset_n = 1'b1;
        run_until_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
